// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
// Holds the controller state encoding and the signed-overflow helper.
package serial_arith_pkg;

    // Controller states; encoding 2'd3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Signed overflow of a - b: operand signs differ and the result sign
    // differs from the minuend sign.
    function automatic logic sub_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow of a single bit position
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin computed LSB first, one bit per
// clock, through a single full-subtractor cell. Operands are captured on an
// accepted start; results hold until the next operation completes.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;

    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state logic: capture on accepted start, shift one bit per SHIFT
    // cycle, and publish the result on the edge that enters DONE. busy lags
    // the state by one cycle so it drops on the same edge that raises done.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {fs_d, res_q[WIDTH-1:1]};
                br_d   = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    diff_d  = {fs_d, res_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
                    ovf_d   = sub_overflow(a_msb_q, b_msb_q, fs_d);
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
    end

    // All state and registered outputs; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance driven with
// directed vectors, held-start traffic and a mid-operation reset, plus a
// 4-bit instance swept over every (a, b, bin) combination.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    // Hand-computed expectation attached to the next accepted 8-bit start
    logic       hand_valid = 1'b0;
    logic [7:0] hand_diff;
    logic       hand_bout, hand_ovf;

    int          cyc8 = 0, bcnt8 = 0, cyc4 = 0, bcnt4 = 0;
    logic        expdone8 = 1'b0, expdone4 = 1'b0;
    logic [31:0] held8 = '0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    // Reference a - b - bin at width w, straight from integer arithmetic
    function automatic exp_t ref_sub(input int w, input logic [31:0] a,
                                     input logic [31:0] b, input logic bin,
                                     input int due);
        exp_t        e;
        logic [31:0] mask;
        logic [32:0] am, bm, full;
        mask   = (32'd1 << w) - 32'd1;
        am     = {1'b0, a & mask};
        bm     = {1'b0, b & mask};
        full   = am - bm - 33'(bin);
        e.diff = full[31:0] & mask;
        e.bout = (am < (bm + 33'(bin)));
        e.ovf  = (a[w-1] ^ b[w-1]) & (e.diff[w-1] ^ a[w-1]);
        e.due  = due;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Acceptance model for the 8-bit unit: push expectations on accepted starts
    always @(posedge clk) begin : model8
        exp_t e;
        cyc8++;
        if (!rst_n) begin
            q8.delete();
            bcnt8    = 0;
            expdone8 = 1'b0;
            held8    = '0;
        end else begin
            expdone8 = 1'b0;
            if (bcnt8 == 0) begin
                if (start8) begin
                    if (hand_valid) begin
                        e.diff = {24'd0, hand_diff};
                        e.bout = hand_bout;
                        e.ovf  = hand_ovf;
                        e.due  = cyc8 + 8;
                    end else begin
                        e = ref_sub(8, {24'd0, a8}, {24'd0, b8}, bin8, cyc8 + 8);
                    end
                    q8.push_back(e);
                    bcnt8 = 8;
                end
            end else begin
                bcnt8--;
                if (bcnt8 == 0) expdone8 = 1'b1;
            end
        end
    end

    // Monitor for the 8-bit unit: handshake every cycle, results on done
    always @(negedge clk) begin : mon8
        exp_t e;
        checkOutput("busy8", {31'd0, busy8}, {31'd0, (bcnt8 >= 1 && bcnt8 <= 7)});
        checkOutput("done8", {31'd0, done8}, {31'd0, expdone8});
        if (done8) begin
            if (q8.size() == 0) begin
                checkOutput("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("diff8", {24'd0, diff8}, e.diff);
                checkOutput("bout8", {31'd0, bout8}, {31'd0, e.bout});
                checkOutput("ovf8",  {31'd0, ovf8},  {31'd0, e.ovf});
                checkOutput("latency8", cyc8, e.due);
                held8 = e.diff;
            end
        end else begin
            checkOutput("hold8", {24'd0, diff8}, held8);
        end
    end

    // Acceptance model for the 4-bit unit
    always @(posedge clk) begin : model4
        cyc4++;
        if (!rst_n) begin
            q4.delete();
            bcnt4    = 0;
            expdone4 = 1'b0;
        end else begin
            expdone4 = 1'b0;
            if (bcnt4 == 0) begin
                if (start4) begin
                    q4.push_back(ref_sub(4, {28'd0, a4}, {28'd0, b4}, bin4, cyc4 + 4));
                    bcnt4 = 4;
                end
            end else begin
                bcnt4--;
                if (bcnt4 == 0) expdone4 = 1'b1;
            end
        end
    end

    // Monitor for the 4-bit unit
    always @(negedge clk) begin : mon4
        exp_t e;
        if (done4 !== expdone4) checkOutput("done4", {31'd0, done4}, {31'd0, expdone4});
        if (done4) begin
            if (q4.size() == 0) begin
                checkOutput("done4_unexpected", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                checkOutput("diff4", {28'd0, diff4}, e.diff);
                checkOutput("bout4", {31'd0, bout4}, {31'd0, e.bout});
                checkOutput("ovf4",  {31'd0, ovf4},  {31'd0, e.ovf});
                checkOutput("latency4", cyc4, e.due);
            end
        end
    end

    task automatic waitDone8();
        int n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done8 !== 1'b1) checkOutput("timeout8", 32'd1, 32'd0);
    endtask

    // Issue one 8-bit operation with its hand-computed result; called at a negedge
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, input logic [7:0] ed,
                                 input logic ebo, input logic eov);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        hand_diff = ed; hand_bout = ebo; hand_ovf = eov; hand_valid = 1'b1;
        @(negedge clk);
        start8 = 1'b0; hand_valid = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        waitDone8();
    endtask

    task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b,
                                  input logic bin);
        int n = 0;
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        while (done4 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (done4 !== 1'b1) checkOutput("timeout4", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_diff8", {24'd0, diff8}, 32'd0);
        checkOutput("rst_bout8", {31'd0, bout8}, 32'd0);
        checkOutput("rst_ovf8",  {31'd0, ovf8},  32'd0);
        checkOutput("rst_diff4", {28'd0, diff4}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        applyStimulus(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        applyStimulus(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        applyStimulus(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        $display("[TB] start held high with operands changing every cycle");
        start8 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0;
        n = 0;
        while (q8.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain8", q8.size(), 32'd0);

        $display("[TB] reset during shift");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        a8 = 8'h5A; b8 = 8'h13; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_diff8", {24'd0, diff8}, 32'd0);
        checkOutput("abort_bout8", {31'd0, bout8}, 32'd0);
        checkOutput("abort_ovf8",  {31'd0, ovf8},  32'd0);
        checkOutput("abort_busy8", {31'd0, busy8}, 32'd0);
        repeat (12) @(negedge clk);
        applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("[TB] exhaustive 4-bit sweep");
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    applyStimulus4(4'(ia), 4'(ib), 1'(ic));

        repeat (12) @(negedge clk);
        checkOutput("final_q8", q8.size(), 32'd0);
        checkOutput("final_q4", q4.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
